// File: rtl/pulse_timestamper.sv
// -----------------------------------------------------------------------------
// pulse_timestamper
//   Fast-domain front end for the neutron detector discriminator. It
//   synchronises the asynchronous comparator output and timestamps each
//   accepted rising edge against a free-running counter. It also measures the
//   time-over-threshold (TOT) of each pulse. Completed events are queued in a
//   first-word-fall-through FIFO with registered outputs. The FIFO is drained
//   through a valid/ready handshake.
//
// Ports
//   CLK_FAST       in   fast clock
//   RESET_FAST     in   asynchronous, active-high reset
//   PULSE_IN       in   comparator output, asynchronous to CLK_FAST
//   ENABLE         in   gates the start of new pulses only
//   EVT_VALID      out  FIFO head holds an event
//   EVT_READY      in   consumer accepts the head
//   EVT_TIMESTAMP  out  head timestamp (TS_WIDTH)
//   EVT_TOT        out  head TOT in cycles (TOT_WIDTH, saturating)
//   EVT_SATURATED  out  head TOT reached its maximum
//   DROP_COUNT     out  events lost to a full FIFO, saturates at 0xFFFF
//   FIFO_LEVEL     out  current FIFO occupancy
// -----------------------------------------------------------------------------
module pulse_timestamper #(
    parameter int TS_WIDTH   = 32,
    parameter int TOT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_TOT    = 2
) (
    input  logic                          CLK_FAST,
    input  logic                          RESET_FAST,
    input  logic                          PULSE_IN,
    input  logic                          ENABLE,
    output logic                          EVT_VALID,
    input  logic                          EVT_READY,
    output logic [TS_WIDTH-1:0]           EVT_TIMESTAMP,
    output logic [TOT_WIDTH-1:0]          EVT_TOT,
    output logic                          EVT_SATURATED,
    output logic [15:0]                   DROP_COUNT,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EVT_W = TS_WIDTH + TOT_WIDTH + 1;
    localparam logic [TOT_WIDTH-1:0] TOT_MAX  = {TOT_WIDTH{1'b1}};
    localparam logic [TOT_WIDTH-1:0] TOT_MIN  = TOT_WIDTH'(MIN_TOT);
    localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    logic                  s1_r, s2_r, s3_r;
    logic [1:0]            prime_r;
    logic                  armed_r;
    logic [TS_WIDTH-1:0]   ts_cnt_r;
    state_t                state_r, state_s;
    logic [TS_WIDTH-1:0]   ev_ts_r, ev_ts_s;
    logic [TOT_WIDTH-1:0]  ev_tot_r, ev_tot_s;
    logic                  ev_sat_r, ev_sat_s;
    logic                  rise_s, fall_s, push_s;

    logic [EVT_W-1:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r, rd_ptr_s;
    logic [LVL_W-1:0]      level_s, remain_s;
    logic [EVT_W-1:0]      push_data_s, head_s;
    logic                  pop_s, full_s, wr_en_s, drop_s;

    assign rise_s = s2_r & ~s3_r;
    assign fall_s = ~s2_r & s3_r;

    // Synchroniser, arming flag and free-running timestamp counter.
    // prime_r marks when s2 carries a real PULSE_IN sample rather than its
    // reset value. Without it, a pulse already high at reset release would
    // look like a fresh rise after a low level.
    always_ff @(posedge CLK_FAST or posedge RESET_FAST) begin
        if (RESET_FAST) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            s3_r     <= 1'b0;
            prime_r  <= 2'b00;
            armed_r  <= 1'b0;
            ts_cnt_r <= {TS_WIDTH{1'b0}};
        end else begin
            s1_r     <= PULSE_IN;
            s2_r     <= s1_r;
            s3_r     <= s2_r;
            prime_r  <= {prime_r[0], 1'b1};
            armed_r  <= armed_r | (prime_r[1] & ~s2_r);
            ts_cnt_r <= ts_cnt_r + TS_WIDTH'(1'b1);
        end
    end

    // Pulse FSM next state: latch on rise, count TOT while high, push on fall.
    always_comb begin
        state_s  = state_r;
        ev_ts_s  = ev_ts_r;
        ev_tot_s = ev_tot_r;
        ev_sat_s = ev_sat_r;
        push_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s && armed_r && ENABLE) begin
                    state_s  = ST_HIGH;
                    ev_ts_s  = ts_cnt_r;
                    ev_tot_s = TOT_WIDTH'(1'b1);
                    ev_sat_s = 1'b0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    state_s = ST_IDLE;
                    push_s  = (ev_tot_r >= TOT_MIN);
                end else if (s2_r) begin
                    if (ev_tot_r != TOT_MAX) begin
                        ev_tot_s = ev_tot_r + TOT_WIDTH'(1'b1);
                        ev_sat_s = ((ev_tot_r + TOT_WIDTH'(1'b1)) == TOT_MAX);
                    end else begin
                        ev_sat_s = 1'b1;
                    end
                end else begin
                    state_s = ST_HIGH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pulse FSM state and in-flight event registers.
    always_ff @(posedge CLK_FAST or posedge RESET_FAST) begin
        if (RESET_FAST) begin
            state_r  <= ST_IDLE;
            ev_ts_r  <= {TS_WIDTH{1'b0}};
            ev_tot_r <= {TOT_WIDTH{1'b0}};
            ev_sat_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            ev_ts_r  <= ev_ts_s;
            ev_tot_r <= ev_tot_s;
            ev_sat_r <= ev_sat_s;
        end
    end

    // FIFO control: accept a push on a full FIFO only when a pop frees a slot.
    // The next head is precomputed so that the outputs can be registered. If
    // the FIFO is empty after this cycle's pop, an incoming push bypasses the
    // storage and goes straight to the head.
    always_comb begin
        push_data_s = {ev_ts_r, ev_tot_r, ev_sat_r};
        pop_s       = EVT_VALID & EVT_READY;
        full_s      = (FIFO_LEVEL == LVL_FULL);
        wr_en_s     = push_s & (~full_s | pop_s);
        drop_s      = push_s & full_s & ~pop_s;
        level_s     = FIFO_LEVEL + LVL_W'(wr_en_s) - LVL_W'(pop_s);
        remain_s    = FIFO_LEVEL - LVL_W'(pop_s);
        rd_ptr_s    = pop_s ? (rd_ptr_r + PTR_W'(1'b1)) : rd_ptr_r;
        head_s      = {EVT_TIMESTAMP, EVT_TOT, EVT_SATURATED};
        if (level_s == {LVL_W{1'b0}}) begin
            head_s = {EVT_TIMESTAMP, EVT_TOT, EVT_SATURATED};
        end else if (remain_s == {LVL_W{1'b0}}) begin
            head_s = push_data_s;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // FIFO storage array.
    always_ff @(posedge CLK_FAST or posedge RESET_FAST) begin
        if (RESET_FAST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {EVT_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, registered head outputs, level and drop counter.
    always_ff @(posedge CLK_FAST or posedge RESET_FAST) begin
        if (RESET_FAST) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            FIFO_LEVEL    <= {LVL_W{1'b0}};
            EVT_VALID     <= 1'b0;
            EVT_TIMESTAMP <= {TS_WIDTH{1'b0}};
            EVT_TOT       <= {TOT_WIDTH{1'b0}};
            EVT_SATURATED <= 1'b0;
            DROP_COUNT    <= 16'h0000;
        end else begin
            wr_ptr_r   <= wr_en_s ? (wr_ptr_r + PTR_W'(1'b1)) : wr_ptr_r;
            rd_ptr_r   <= rd_ptr_s;
            FIFO_LEVEL <= level_s;
            EVT_VALID  <= (level_s != {LVL_W{1'b0}});
            {EVT_TIMESTAMP, EVT_TOT, EVT_SATURATED} <= head_s;
            if (drop_s && (DROP_COUNT != 16'hFFFF)) begin
                DROP_COUNT <= DROP_COUNT + 16'h0001;
            end else begin
                DROP_COUNT <= DROP_COUNT;
            end
        end
    end

endmodule

// File: tb/tb_pulse_timestamper.sv
// -----------------------------------------------------------------------------
// tb_pulse_timestamper
//   Self-checking bench for pulse_timestamper. PULSE_IN is driven cycle by
//   cycle and every driven cycle is recorded. A pulse is a maximal run of high
//   cycles [a, a+L-1] after reset release. It produces an event
//   {ts=a+2, tot=min(L,255), sat=L>=255} at the end of cycle a+L+2 if:
//     - a low cycle preceded the run since release,
//     - ENABLE was high in cycle a+2, and
//     - L >= MIN_TOT.
//   Events enter a queue that mirrors the FIFO contents seen on the outputs.
//   The timestamp counter is narrowed to 12 bits so that a wrap can be
//   reached in a short run.
// -----------------------------------------------------------------------------
module tb_pulse_timestamper;

    localparam int TSW   = 12;
    localparam int TOTW  = 8;
    localparam int DEPTH = 16;
    localparam int MINT  = 2;
    localparam int MAXC  = 65536;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pulse = 1'b0;
    logic            en = 1'b1;
    logic            ready = 1'b1;
    logic            valid;
    logic [TSW-1:0]  ts;
    logic [TOTW-1:0] tot;
    logic            sat;
    logic [15:0]     drops;
    logic [4:0]      level;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [TSW-1:0]  ts;
        logic [TOTW-1:0] tot;
        logic            sat;
    } evt_t;

    typedef struct {
        int len;
        bit en;
        bit exp_evt;
        int exp_tot;
        bit exp_sat;
    } vec_t;

    bit   hp [MAXC];
    bit   he [MAXC];
    int   cyc;
    int   m_drops;
    evt_t q[$];
    vec_t vecs[8];

    int seen, got_tot, got_sat, got_ts, drained;

    pulse_timestamper #(
        .TS_WIDTH   (TSW),
        .TOT_WIDTH  (TOTW),
        .FIFO_DEPTH (DEPTH),
        .MIN_TOT    (MINT)
    ) dut (
        .CLK_FAST      (clk),
        .RESET_FAST    (rst),
        .PULSE_IN      (pulse),
        .ENABLE        (en),
        .EVT_VALID     (valid),
        .EVT_READY     (ready),
        .EVT_TIMESTAMP (ts),
        .EVT_TOT       (tot),
        .EVT_SATURATED (sat),
        .DROP_COUNT    (drops),
        .FIFO_LEVEL    (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: model the end of the current cycle, then compare.
    task automatic tick();
        bit   pop;
        bit   push;
        int   a;
        int   len;
        int   sz;
        evt_t e;
        if (cyc >= MAXC - 1) begin
            $display("FAIL history: cycle budget exceeded at cycle %0d", cyc);
            $fatal(1, "history overflow");
        end
        hp[cyc] = pulse;
        he[cyc] = en;
        sz   = q.size();
        pop  = (sz > 0) && ready;
        push = 1'b0;
        e    = '{ts: '0, tot: '0, sat: 1'b0};
        if (cyc >= 3 && hp[cyc-3] && !hp[cyc-2]) begin
            a = cyc - 3;
            while (a > 0 && hp[a-1]) a--;
            len = cyc - 2 - a;
            if (a >= 1 && he[a+2] && len >= MINT) begin
                push  = 1'b1;
                e.ts  = TSW'(a + 2);
                e.tot = (len >= 255) ? 8'd255 : TOTW'(len);
                e.sat = (len >= 255);
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (sz == DEPTH && !pop) begin
                if (m_drops < 65535) m_drops++;
            end else begin
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("valid", valid, (q.size() > 0) ? 1 : 0);
        check("level", level, q.size());
        check("drop_count", drops, m_drops);
        if (q.size() > 0) begin
            check("head_ts", ts, q[0].ts);
            check("head_tot", tot, q[0].tot);
            check("head_sat", sat, q[0].sat);
        end
    endtask

    task automatic run(input bit p, input int n);
        pulse = p;
        repeat (n) tick();
    endtask

    task automatic run_rand(input bit p, input int n, input int ready_bias);
        pulse = p;
        repeat (n) begin
            ready = ($urandom_range(0, 7) < ready_bias);
            tick();
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        #1;
        check("rst_valid", valid, 0);
        check("rst_ts", ts, 0);
        check("rst_tot", tot, 0);
        check("rst_sat", sat, 0);
        check("rst_drops", drops, 0);
        check("rst_level", level, 0);
        repeat (ncyc) @(posedge clk);
        #1;
        rst     = 1'b0;
        cyc     = 0;
        m_drops = 0;
        q.delete();
    endtask

    // Watch n cycles and capture the first event seen on the outputs.
    task automatic watch(input int n);
        seen = 0;
        repeat (n) begin
            tick();
            if (valid && seen == 0) begin
                seen    = 1;
                got_tot = int'(tot);
                got_sat = int'(sat);
                got_ts  = int'(ts);
            end
        end
    endtask

    initial begin
        vecs[0] = '{len: 10,  en: 1'b1, exp_evt: 1'b1, exp_tot: 10,  exp_sat: 1'b0};
        vecs[1] = '{len: 1,   en: 1'b1, exp_evt: 1'b0, exp_tot: 0,   exp_sat: 1'b0};
        vecs[2] = '{len: 2,   en: 1'b1, exp_evt: 1'b1, exp_tot: 2,   exp_sat: 1'b0};
        vecs[3] = '{len: 3,   en: 1'b0, exp_evt: 1'b0, exp_tot: 0,   exp_sat: 1'b0};
        vecs[4] = '{len: 300, en: 1'b1, exp_evt: 1'b1, exp_tot: 255, exp_sat: 1'b1};
        vecs[5] = '{len: 254, en: 1'b1, exp_evt: 1'b1, exp_tot: 254, exp_sat: 1'b0};
        vecs[6] = '{len: 255, en: 1'b1, exp_evt: 1'b1, exp_tot: 255, exp_sat: 1'b1};
        vecs[7] = '{len: 7,   en: 1'b1, exp_evt: 1'b1, exp_tot: 7,   exp_sat: 1'b0};
        cyc = 0;
        m_drops = 0;

        do_reset(3);

        // Basic event: high at counter 100 for 10 cycles.
        run(1'b0, 100);
        run(1'b1, 10);
        pulse = 1'b0;
        while (cyc < 115) begin
            tick();
            if (cyc == 112) check("basic_before", valid, 0);
            if (cyc == 113) begin
                check("basic_valid", valid, 1);
                check("basic_ts", ts, 102);
                check("basic_tot", tot, 10);
                check("basic_sat", sat, 0);
            end
            if (cyc == 114) check("basic_after", valid, 0);
        end

        // Table of single pulses.
        for (int i = 0; i < 8; i++) begin
            en = vecs[i].en;
            run(1'b0, 4);
            run(1'b1, vecs[i].len);
            pulse = 1'b0;
            watch(8);
            en = 1'b1;
            check("vec_event", seen, vecs[i].exp_evt);
            if (vecs[i].exp_evt) begin
                check("vec_tot", got_tot, vecs[i].exp_tot);
                check("vec_sat", got_sat, vecs[i].exp_sat);
            end
            check("vec_level", level, 0);
            check("vec_drops", drops, 0);
        end

        // ENABLE dropped mid-pulse does not abort it.
        run(1'b0, 4);
        run(1'b1, 3);
        en = 1'b0;
        run(1'b1, 3);
        pulse = 1'b0;
        watch(8);
        en = 1'b1;
        check("en_mid_event", seen, 1);
        check("en_mid_tot", got_tot, 6);

        // Rise in the cycle after a fall: both pulses recorded.
        drained = 0;
        run(1'b1, 3);
        run(1'b0, 1);
        pulse = 1'b1;
        repeat (3) begin tick(); if (valid) drained++; end
        pulse = 1'b0;
        repeat (10) begin tick(); if (valid) drained++; end
        check("back_to_back_count", drained, 2);

        // Overflow: 20 pulses into a stalled FIFO.
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            run(1'b1, 4);
            run(1'b0, 4);
        end
        run(1'b0, 4);
        check("ovf_level", level, 16);
        check("ovf_drops", drops, 4);

        // Full with a simultaneous pop: push lands in the pop cycle.
        run(1'b1, 4);
        pulse = 1'b0;
        tick();
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("fullpop_level", level, 16);
        check("fullpop_drops", drops, 4);

        // Drain.
        ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 40 && level != 0; i++) begin
            if (valid) drained++;
            tick();
        end
        check("drain_count", drained, 16);
        check("drain_level", level, 0);

        // Reset mid-pulse with PULSE_IN still high at release.
        run(1'b1, 5);
        do_reset(2);
        pulse = 1'b1;
        watch(12);
        check("rst_hi_event", seen, 0);
        check("rst_hi_level", level, 0);
        run(1'b0, 3);
        run(1'b1, 5);
        pulse = 1'b0;
        watch(8);
        check("rearm_event", seen, 1);
        check("rearm_tot", got_tot, 5);

        // Counter wrap while HIGH keeps the latched timestamp.
        pulse = 1'b0;
        for (int i = 0; i < 5000 && (cyc % 4096) != 4091; i++) tick();
        check("wrap_align", cyc % 4096, 4091);
        run(1'b1, 8);
        pulse = 1'b0;
        watch(8);
        check("wrap_event", seen, 1);
        check("wrap_ts", got_ts, 4093);
        check("wrap_tot", got_tot, 8);

        // Randomized pulses, enables and backpressure against the model.
        for (int i = 0; i < 250; i++) begin
            int bias;
            bias = (i % 50 < 10) ? 1 : 6;
            en = ($urandom_range(0, 7) != 0);
            run_rand(1'b1, $urandom_range(1, 12), bias);
            run_rand(1'b0, $urandom_range(1, 6), bias);
        end
        en = 1'b1;
        ready = 1'b1;
        run(1'b0, 40);
        check("final_level", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
